// File: rtl/fft8.sv
// Pipelined 8-point radix-2 DIT FFT on real Q8.8 samples; complex Q8.8 output, no scaling.
// Four register stages (input, stage 1, stage 2, output), one transform per clock.
module fft8 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inp1,
    input  logic [15:0] inp2,
    input  logic [15:0] inp3,
    input  logic [15:0] inp4,
    input  logic [15:0] inp5,
    input  logic [15:0] inp6,
    input  logic [15:0] inp7,
    input  logic [15:0] inp8,
    output logic [15:0] out1_real,
    output logic [15:0] out2_real,
    output logic [15:0] out3_real,
    output logic [15:0] out4_real,
    output logic [15:0] out5_real,
    output logic [15:0] out6_real,
    output logic [15:0] out7_real,
    output logic [15:0] out8_real,
    output logic [15:0] out1_imag,
    output logic [15:0] out2_imag,
    output logic [15:0] out3_imag,
    output logic [15:0] out4_imag,
    output logic [15:0] out5_imag,
    output logic [15:0] out6_imag,
    output logic [15:0] out7_imag,
    output logic [15:0] out8_imag,
    output logic        out_stb
);

    localparam logic signed [31:0] TwC = 32'sd181;

    // Held in bit-reversed order: x0,x4,x2,x6,x1,x5,x3,x7.
    logic signed [15:0] in_q     [8];
    logic signed [15:0] s1_q     [8];
    logic signed [15:0] s1_d     [8];
    logic signed [15:0] s2_re_q  [8];
    logic signed [15:0] s2_im_q  [8];
    logic signed [15:0] s2_re_d  [8];
    logic signed [15:0] s2_im_d  [8];
    logic signed [15:0] out_re_q [8];
    logic signed [15:0] out_im_q [8];
    logic signed [15:0] out_re_d [8];
    logic signed [15:0] out_im_d [8];
    logic signed [15:0] tw_re    [4];
    logic signed [15:0] tw_im    [4];
    logic        [2:0]  fill_q;

    // Multiply by C (~0.7071), floor shift by 8, keep low 16 bits.
    function automatic logic signed [15:0] cmul(input logic signed [15:0] v);
        logic signed [31:0] p;
        p = $signed({{16{v[15]}}, v}) * TwC;
        return 16'(p >>> 8);
    endfunction

    // Stage 1: W^0 butterflies on real inputs only.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s1_d[2*i]   = in_q[2*i] + in_q[2*i+1];
            s1_d[2*i+1] = in_q[2*i] - in_q[2*i+1];
        end
    end

    // Stage 2: span-2 butterflies; W^2 = -j applied to a purely real operand.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            s2_re_d[4*g]   = s1_q[4*g] + s1_q[4*g+2];
            s2_im_d[4*g]   = 16'sd0;
            s2_re_d[4*g+2] = s1_q[4*g] - s1_q[4*g+2];
            s2_im_d[4*g+2] = 16'sd0;
            s2_re_d[4*g+1] = s1_q[4*g+1];
            s2_im_d[4*g+1] = -s1_q[4*g+3];
            s2_re_d[4*g+3] = s1_q[4*g+1];
            s2_im_d[4*g+3] = s1_q[4*g+3];
        end
    end

    // Stage 3: twiddle the lower half, then span-4 butterflies into natural order.
    always_comb begin
        logic signed [15:0] sum1, dif1, dif3, nsum3;
        sum1  = s2_re_q[5] + s2_im_q[5];
        dif1  = s2_im_q[5] - s2_re_q[5];
        dif3  = s2_im_q[7] - s2_re_q[7];
        nsum3 = -(s2_re_q[7] + s2_im_q[7]);
        tw_re[0] = s2_re_q[4];
        tw_im[0] = s2_im_q[4];
        tw_re[1] = cmul(sum1);
        tw_im[1] = cmul(dif1);
        tw_re[2] = s2_im_q[6];
        tw_im[2] = -s2_re_q[6];
        tw_re[3] = cmul(dif3);
        tw_im[3] = cmul(nsum3);
        for (int k = 0; k < 4; k++) begin
            out_re_d[k]   = s2_re_q[k] + tw_re[k];
            out_im_d[k]   = s2_im_q[k] + tw_im[k];
            out_re_d[k+4] = s2_re_q[k] - tw_re[k];
            out_im_d[k+4] = s2_im_q[k] - tw_im[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                in_q[i]     <= '0;
                s1_q[i]     <= '0;
                s2_re_q[i]  <= '0;
                s2_im_q[i]  <= '0;
                out_re_q[i] <= '0;
                out_im_q[i] <= '0;
            end
            fill_q <= '0;
        end else begin
            in_q[0] <= inp1;
            in_q[1] <= inp5;
            in_q[2] <= inp3;
            in_q[3] <= inp7;
            in_q[4] <= inp2;
            in_q[5] <= inp6;
            in_q[6] <= inp4;
            in_q[7] <= inp8;
            for (int i = 0; i < 8; i++) begin
                s1_q[i]     <= s1_d[i];
                s2_re_q[i]  <= s2_re_d[i];
                s2_im_q[i]  <= s2_im_d[i];
                out_re_q[i] <= out_re_d[i];
                out_im_q[i] <= out_im_d[i];
            end
            if (fill_q != 3'd7) begin
                fill_q <= fill_q + 3'd1;
            end
        end
    end

    // Pipeline is full once four edges have passed since reset release.
    assign out_stb = fill_q[2];

    assign out1_real = out_re_q[0];
    assign out2_real = out_re_q[1];
    assign out3_real = out_re_q[2];
    assign out4_real = out_re_q[3];
    assign out5_real = out_re_q[4];
    assign out6_real = out_re_q[5];
    assign out7_real = out_re_q[6];
    assign out8_real = out_re_q[7];
    assign out1_imag = out_im_q[0];
    assign out2_imag = out_im_q[1];
    assign out3_imag = out_im_q[2];
    assign out4_imag = out_im_q[3];
    assign out5_imag = out_im_q[4];
    assign out6_imag = out_im_q[5];
    assign out7_imag = out_im_q[6];
    assign out8_imag = out_im_q[7];

endmodule

// File: tb/tb_fft8.sv
// Directed bench for fft8: reset, fill latency, fixed patterns, streaming and mid-run reset.
module tb_fft8;

    logic        clk;
    logic        rst;
    logic [15:0] in_v   [8];
    logic [15:0] out_re [8];
    logic [15:0] out_im [8];
    logic        out_stb;

    int total;
    int bad;

    // Patterns: 0 ramp, 1 impulse, 2 dc, 3 alternating, 4 overflow.
    logic [15:0] pin [5][8];
    logic [15:0] pre [5][8];
    logic [15:0] pim [5][8];

    fft8 dut (
        .clk       (clk),
        .rst       (rst),
        .inp1      (in_v[0]),
        .inp2      (in_v[1]),
        .inp3      (in_v[2]),
        .inp4      (in_v[3]),
        .inp5      (in_v[4]),
        .inp6      (in_v[5]),
        .inp7      (in_v[6]),
        .inp8      (in_v[7]),
        .out1_real (out_re[0]),
        .out2_real (out_re[1]),
        .out3_real (out_re[2]),
        .out4_real (out_re[3]),
        .out5_real (out_re[4]),
        .out6_real (out_re[5]),
        .out7_real (out_re[6]),
        .out8_real (out_re[7]),
        .out1_imag (out_im[0]),
        .out2_imag (out_im[1]),
        .out3_imag (out_im[2]),
        .out4_imag (out_im[3]),
        .out5_imag (out_im[4]),
        .out6_imag (out_im[5]),
        .out7_imag (out_im[6]),
        .out8_imag (out_im[7]),
        .out_stb   (out_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_tables();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 8; i++) begin
                pre[p][i] = 16'h0000;
                pim[p][i] = 16'h0000;
            end
        end
        for (int i = 0; i < 8; i++) begin
            pin[0][i] = 16'(i * 256);
            pin[1][i] = (i == 0) ? 16'h0100 : 16'h0000;
            pin[2][i] = 16'h0100;
            pin[3][i] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
            pin[4][i] = 16'h7F00;
            pre[0][i] = 16'hFC00;
            pre[1][i] = 16'h0100;
        end
        pre[0][0] = 16'h1C00;
        pim[0][1] = 16'h09A8;
        pim[0][2] = 16'h0400;
        pim[0][3] = 16'h01A8;
        pim[0][5] = 16'hFE58;
        pim[0][6] = 16'hFC00;
        pim[0][7] = 16'hF658;
        pre[2][0] = 16'h0800;
        pre[3][4] = 16'h0800;
        pre[4][0] = 16'hF800;
    endtask

    task automatic drive(input int p);
        for (int i = 0; i < 8; i++) in_v[i] = pin[p][i];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 8; i++) in_v[i] = 16'($urandom);
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                total++;
                if (out_re[k] !== 16'h0000 || out_im[k] !== 16'h0000) begin
                    bad++;
                    $display("FAIL reset X%0d got %h/%h want 0000/0000", k, out_re[k], out_im[k]);
                end
            end
            total++;
            if (out_stb !== 1'b0) begin
                bad++;
                $display("FAIL reset_stb got %b want 0", out_stb);
            end
        end
    endtask

    task automatic test_fill_ramp();
        drive(0);
        rst = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            total++;
            if (out_stb !== (e == 4)) begin
                bad++;
                $display("FAIL fill_stb edge %0d got %b want %b", e, out_stb, (e == 4));
            end
            if (e < 4) begin
                total++;
                if (out_re[0] !== 16'h0000) begin
                    bad++;
                    $display("FAIL fill_early edge %0d X0 real got %h want 0000", e, out_re[0]);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (out_re[k] !== pre[0][k] || out_im[k] !== pim[0][k]) begin
                bad++;
                $display("FAIL ramp X%0d got %h/%h want %h/%h",
                         k, out_re[k], out_im[k], pre[0][k], pim[0][k]);
            end
        end
    endtask

    task automatic test_patterns();
        for (int p = 1; p < 5; p++) begin
            drive(p);
            repeat (4) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                total++;
                if (out_re[k] !== pre[p][k] || out_im[k] !== pim[p][k]) begin
                    bad++;
                    $display("FAIL pattern%0d X%0d got %h/%h want %h/%h",
                             p, k, out_re[k], out_im[k], pre[p][k], pim[p][k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int seq [10] = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0};
        for (int i = 0; i < 14; i++) begin
            if (i >= 4) begin
                for (int k = 0; k < 8; k++) begin
                    total++;
                    if (out_re[k] !== pre[seq[i-4]][k] || out_im[k] !== pim[seq[i-4]][k]) begin
                        bad++;
                        $display("FAIL stream v%0d X%0d got %h/%h want %h/%h", i - 4, k,
                                 out_re[k], out_im[k], pre[seq[i-4]][k], pim[seq[i-4]][k]);
                    end
                end
            end
            if (i < 10) drive(seq[i]);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 6; i++) begin
            drive(i % 5);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (out_re[k] !== 16'h0000 || out_im[k] !== 16'h0000) begin
                bad++;
                $display("FAIL midrst X%0d got %h/%h want 0000/0000", k, out_re[k], out_im[k]);
            end
        end
        total++;
        if (out_stb !== 1'b0) begin
            bad++;
            $display("FAIL midrst_stb got %b want 0", out_stb);
        end
        @(negedge clk);
        drive(2);
        rst = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            total++;
            if (out_stb !== (e == 4)) begin
                bad++;
                $display("FAIL recover_stb edge %0d got %b want %b", e, out_stb, (e == 4));
            end
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (out_re[k] !== pre[2][k] || out_im[k] !== pim[2][k]) begin
                bad++;
                $display("FAIL recover X%0d got %h/%h want %h/%h",
                         k, out_re[k], out_im[k], pre[2][k], pim[2][k]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        set_tables();
        drive(0);
        test_reset();
        test_fill_ramp();
        test_patterns();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
